// File: rtl/noise_pkg.sv
// Shared definitions for the noise source: LFSR geometry, reset seed, tap
// positions, single-step helper and the warm-up/run state encoding.
package noise_pkg;

  localparam int LFSR_W = 32;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'hACE1_5EED;

  // Taps for x^32 + x^22 + x^2 + x + 1 in a left-shifting Fibonacci LFSR.
  localparam int TAP0 = 31;
  localparam int TAP1 = 21;
  localparam int TAP2 = 1;
  localparam int TAP3 = 0;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  // Returns {next_state, produced_bit}.
  function automatic logic [LFSR_W:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic b;
    b = s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3];
    return {s[LFSR_W-2:0], b, b};
  endfunction

  function automatic int tri_idx(input int n);
    return n * (n + 1) / 2;
  endfunction

endpackage

// File: rtl/lfsr_unroll.sv
// K chained LFSR steps in one combinational cone; f_o[0] is the first bit out.
module lfsr_unroll
  import noise_pkg::*;
#(
  parameter int K = 10
) (
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] state_o,
  output logic [K-1:0]      f_o
);

  always_comb begin
    logic [LFSR_W-1:0] s;
    logic [LFSR_W:0]   r;
    s   = state_i;
    r   = '0;
    f_o = '0;
    for (int i = 0; i < K; i++) begin
      r      = lfsr_step(s);
      s      = r[LFSR_W:1];
      f_o[i] = r[0];
    end
    state_o = s;
  end

endmodule

// File: rtl/noise_source.sv
// Multi-channel biased noise generator: channel n is 1 with probability
// 1/2^(n+1), built from disjoint groups of freshly generated LFSR bits.
module noise_source
  import noise_pkg::*;
#(
  parameter int NCHAN  = 4,
  parameter int WARMUP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic [NCHAN-1:0]  nois,
  output logic              valid
);

  localparam int K = NCHAN * (NCHAN + 1) / 2;
  localparam logic [7:0] CNT_LAST = 8'(WARMUP - 1);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic [K-1:0]      f;
  logic [NCHAN-1:0]  chan_d;
  logic [NCHAN-1:0]  nois_q;
  logic              valid_q;
  logic [7:0]        cnt_q;
  state_e            state_q;
  logic [LFSR_W-1:0] seed_d;

  lfsr_unroll #(.K(K)) u_unroll (
    .state_i (lfsr_q),
    .state_o (lfsr_d),
    .f_o     (f)
  );

  // Channel n ANDs n+1 consecutive fresh bits starting at T(n).
  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
    localparam int BASE = tri_idx(gi);
    assign chan_d[gi] = &f[BASE +: gi + 1];
  end

  // A zero seed would lock the LFSR, so substitute the default.
  assign seed_d = (seed == '0) ? DEFAULT_SEED : seed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q  <= DEFAULT_SEED;
      nois_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= ST_WARMUP;
    end else if (seed_load) begin
      lfsr_q  <= seed_d;
      nois_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= ST_WARMUP;
    end else if (en) begin
      lfsr_q <= lfsr_d;
      case (state_q)
        ST_WARMUP: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_RUN;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            nois_q  <= chan_d;
          end else begin
            cnt_q  <= cnt_q + 8'd1;
            nois_q <= '0;
          end
        end
        ST_RUN: begin
          nois_q  <= chan_d;
          valid_q <= 1'b1;
        end
        default: begin
          state_q <= ST_WARMUP;
          nois_q  <= '0;
          valid_q <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign nois  = nois_q;
  assign valid = valid_q;

endmodule
